// File: rtl/mem_rr_scheduler_if.sv
// Consumer-side and memory-side valid/ready bundle for mem_rr_scheduler.
// Element j of each packed array is the flat slice [j*WIDTH +: WIDTH].
interface mem_rr_scheduler_if #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]                c_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] c_read_address;
    logic [NUM_CONSUMERS-1:0]                c_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_read_data;
    logic [NUM_CONSUMERS-1:0]                c_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] c_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_write_data;
    logic [NUM_CONSUMERS-1:0]                c_write_ready;

    logic [NUM_CHANNELS-1:0]                 m_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_read_address;
    logic [NUM_CHANNELS-1:0]                 m_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_read_data;
    logic [NUM_CHANNELS-1:0]                 m_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_write_data;
    logic [NUM_CHANNELS-1:0]                 m_write_ready;

    // Scheduler view.
    modport slave (
        input  c_read_valid, c_read_address, c_write_valid, c_write_address, c_write_data,
        input  m_read_ready, m_read_data, m_write_ready,
        output c_read_ready, c_read_data, c_write_ready,
        output m_read_valid, m_read_address, m_write_valid, m_write_address, m_write_data
    );

    // Consumers plus memory view.
    modport master (
        output c_read_valid, c_read_address, c_write_valid, c_write_address, c_write_data,
        output m_read_ready, m_read_data, m_write_ready,
        input  c_read_ready, c_read_data, c_write_ready,
        input  m_read_valid, m_read_address, m_write_valid, m_write_address, m_write_data
    );
endinterface

// File: rtl/mem_rr_scheduler.sv
// Rotating-priority scheduler sharing NUM_CHANNELS memory channels among NUM_CONSUMERS
// requesters, with saturating per-consumer grant counters.
module mem_rr_scheduler #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter bit          WRITE_ENABLE  = 1'b1,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    mem_rr_scheduler_if.slave                       bus,
    output logic [NUM_CONSUMERS-1:0][CNT_BITS-1:0]  grant_count,
    output logic                                    busy
);
    localparam int unsigned PTR_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [2:0] {
        StIdle,
        StReadWaiting,
        StWriteWaiting,
        StReadRelaying,
        StWriteRelaying
    } ch_state_e;

    ch_state_e                state_q [NUM_CHANNELS];
    logic [PTR_BITS-1:0]      owner_q [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] owned_q;
    logic [PTR_BITS-1:0]      rr_ptr_q;

    logic [NUM_CONSUMERS-1:0] eligible;
    logic [NUM_CHANNELS-1:0]  grant_vld;
    logic [NUM_CHANNELS-1:0]  grant_rd;
    logic [PTR_BITS-1:0]      grant_idx [NUM_CHANNELS];
    logic [PTR_BITS-1:0]      rr_ptr_d;
    logic                     busy_d;

    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic [PTR_BITS:0]        sum;
        logic [PTR_BITS-1:0]      idx;
        taken     = '0;
        sum       = '0;
        idx       = '0;
        grant_vld = '0;
        grant_rd  = '0;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) grant_idx[c] = '0;

        eligible = (bus.c_read_valid | (bus.c_write_valid & {NUM_CONSUMERS{WRITE_ENABLE}}))
                   & ~owned_q;

        // Idle channels take turns in index order, each scanning circularly from rr_ptr.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == StIdle) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    sum = {1'b0, rr_ptr_q} + (PTR_BITS+1)'(k);
                    if (sum >= (PTR_BITS+1)'(NUM_CONSUMERS)) begin
                        sum = sum - (PTR_BITS+1)'(NUM_CONSUMERS);
                    end
                    idx = sum[PTR_BITS-1:0];
                    if (!grant_vld[c] && eligible[idx] && !taken[idx]) begin
                        grant_vld[c] = 1'b1;
                        grant_idx[c] = idx;
                        grant_rd[c]  = bus.c_read_valid[idx];
                        taken[idx]   = 1'b1;
                        rr_ptr_d     = (idx == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0 : idx + 1'b1;
                    end
                end
            end
        end

        // busy mirrors the channel states that will hold after this edge.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                StIdle:          if (grant_vld[c]) busy_d = 1'b1;
                StReadRelaying:  if (bus.c_read_valid[owner_q[c]]) busy_d = 1'b1;
                StWriteRelaying: if (bus.c_write_valid[owner_q[c]]) busy_d = 1'b1;
                default:         busy_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= StIdle;
                owner_q[c] <= '0;
            end
            owned_q             <= '0;
            rr_ptr_q            <= '0;
            grant_count         <= '0;
            busy                <= 1'b0;
            bus.c_read_ready    <= '0;
            bus.c_read_data     <= '0;
            bus.c_write_ready   <= '0;
            bus.m_read_valid    <= '0;
            bus.m_read_address  <= '0;
            bus.m_write_valid   <= '0;
            bus.m_write_address <= '0;
            bus.m_write_data    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            busy     <= busy_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    StIdle: begin
                        if (grant_vld[c]) begin
                            owner_q[c]                <= grant_idx[c];
                            owned_q[grant_idx[c]]     <= 1'b1;
                            if (grant_count[grant_idx[c]] != '1) begin
                                grant_count[grant_idx[c]] <= grant_count[grant_idx[c]] + 1'b1;
                            end
                            if (grant_rd[c]) begin
                                state_q[c]            <= StReadWaiting;
                                bus.m_read_valid[c]   <= 1'b1;
                                bus.m_read_address[c] <= bus.c_read_address[grant_idx[c]];
                            end else if (WRITE_ENABLE) begin
                                state_q[c]             <= StWriteWaiting;
                                bus.m_write_valid[c]   <= 1'b1;
                                bus.m_write_address[c] <= bus.c_write_address[grant_idx[c]];
                                bus.m_write_data[c]    <= bus.c_write_data[grant_idx[c]];
                            end
                        end
                    end
                    StReadWaiting: begin
                        if (bus.m_read_ready[c]) begin
                            bus.m_read_valid[c]            <= 1'b0;
                            bus.c_read_ready[owner_q[c]]   <= 1'b1;
                            bus.c_read_data[owner_q[c]]    <= bus.m_read_data[c];
                            state_q[c]                     <= StReadRelaying;
                        end
                    end
                    StWriteWaiting: begin
                        if (bus.m_write_ready[c]) begin
                            bus.m_write_valid[c]           <= 1'b0;
                            bus.c_write_ready[owner_q[c]]  <= 1'b1;
                            state_q[c]                     <= StWriteRelaying;
                        end
                    end
                    StReadRelaying: begin
                        if (!bus.c_read_valid[owner_q[c]]) begin
                            bus.c_read_ready[owner_q[c]]   <= 1'b0;
                            owned_q[owner_q[c]]            <= 1'b0;
                            state_q[c]                     <= StIdle;
                        end
                    end
                    StWriteRelaying: begin
                        if (!bus.c_write_valid[owner_q[c]]) begin
                            bus.c_write_ready[owner_q[c]]  <= 1'b0;
                            owned_q[owner_q[c]]            <= 1'b0;
                            state_q[c]                     <= StIdle;
                        end
                    end
                    default: state_q[c] <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed bench for mem_rr_scheduler: one-channel, two-channel and write-disabled instances
// share a clock and reset.
module tb_mem_rr_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [3:0][15:0] gc1, gc2, gc3;
    logic             busy1, busy2, busy3;

    mem_rr_scheduler_if #(.NUM_CHANNELS(1)) bus1 ();
    mem_rr_scheduler_if #(.NUM_CHANNELS(2)) bus2 ();
    mem_rr_scheduler_if #(.NUM_CHANNELS(1)) bus3 ();

    mem_rr_scheduler #(.NUM_CHANNELS(1), .WRITE_ENABLE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .grant_count(gc1), .busy(busy1));
    mem_rr_scheduler #(.NUM_CHANNELS(2), .WRITE_ENABLE(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .grant_count(gc2), .busy(busy2));
    mem_rr_scheduler #(.NUM_CHANNELS(1), .WRITE_ENABLE(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .grant_count(gc3), .busy(busy3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus1.c_read_valid = '0; bus1.c_read_address = '0; bus1.c_write_valid = '0;
        bus1.c_write_address = '0; bus1.c_write_data = '0; bus1.m_read_ready = '0;
        bus1.m_read_data = '0; bus1.m_write_ready = '0;
        bus2.c_read_valid = '0; bus2.c_read_address = '0; bus2.c_write_valid = '0;
        bus2.c_write_address = '0; bus2.c_write_data = '0; bus2.m_read_ready = '0;
        bus2.m_read_data = '0; bus2.m_write_ready = '0;
        bus3.c_read_valid = '0; bus3.c_read_address = '0; bus3.c_write_valid = '0;
        bus3.c_write_address = '0; bus3.c_write_data = '0; bus3.m_read_ready = '0;
        bus3.m_read_data = '0; bus3.m_write_ready = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus1.m_read_valid !== 1'b0) begin errors++;
            $display("FAIL reset_m_read_valid got %0b want 0", bus1.m_read_valid); end
        checks++; if (bus1.m_read_address[0] !== 8'h00) begin errors++;
            $display("FAIL reset_m_read_address got %h want 00", bus1.m_read_address[0]); end
        checks++; if (bus1.m_write_valid !== 1'b0) begin errors++;
            $display("FAIL reset_m_write_valid got %0b want 0", bus1.m_write_valid); end
        checks++; if (bus1.c_read_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_c_read_ready got %b want 0000", bus1.c_read_ready); end
        checks++; if (bus1.c_write_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_c_write_ready got %b want 0000", bus1.c_write_ready); end
        checks++; if (gc1 !== 64'h0) begin errors++;
            $display("FAIL reset_grant_count got %h want 0", gc1); end
        checks++; if (busy1 !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %0b want 0", busy1); end
        checks++; if (bus2.m_read_valid !== 2'b00) begin errors++;
            $display("FAIL reset_dut2_m_read_valid got %b want 00", bus2.m_read_valid); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus1.c_read_valid[2] = 1'b1;
        bus1.c_read_address[2] = 8'h3C;
        tick();
        checks++; if (bus1.m_read_valid !== 1'b1) begin errors++;
            $display("FAIL single_m_read_valid got %0b want 1", bus1.m_read_valid); end
        checks++; if (bus1.m_read_address[0] !== 8'h3C) begin errors++;
            $display("FAIL single_m_read_address got %h want 3c", bus1.m_read_address[0]); end
        checks++; if (gc1[2] !== 16'd1) begin errors++;
            $display("FAIL single_grant_count2 got %0d want 1", gc1[2]); end
        checks++; if (busy1 !== 1'b1) begin errors++;
            $display("FAIL single_busy got %0b want 1", busy1); end
        bus1.m_read_ready[0] = 1'b1;
        bus1.m_read_data[0] = 16'hBEEF;
        tick();
        checks++; if (bus1.c_read_ready !== 4'b0100) begin errors++;
            $display("FAIL single_c_read_ready got %b want 0100", bus1.c_read_ready); end
        checks++; if (bus1.c_read_data[2] !== 16'hBEEF) begin errors++;
            $display("FAIL single_c_read_data got %h want beef", bus1.c_read_data[2]); end
        checks++; if (bus1.m_read_valid !== 1'b0) begin errors++;
            $display("FAIL single_m_read_valid_drop got %0b want 0", bus1.m_read_valid); end
        bus1.m_read_ready = '0;
        bus1.m_read_data = '0;
        bus1.c_read_valid = '0;
        tick();
        checks++; if (bus1.c_read_ready !== 4'b0000) begin errors++;
            $display("FAIL single_ready_drop got %b want 0000", bus1.c_read_ready); end
        checks++; if (bus1.c_read_data[2] !== 16'hBEEF) begin errors++;
            $display("FAIL single_data_hold got %h want beef", bus1.c_read_data[2]); end
        checks++; if (busy1 !== 1'b0) begin errors++;
            $display("FAIL single_busy_end got %0b want 0", busy1); end
    endtask

    task automatic test_fairness();
        int grants;
        int cyc;
        logic [7:0] want;
        grants = 0;
        cyc = 0;
        do_reset();
        for (int j = 0; j < 4; j++) bus1.c_read_address[j] = 8'(16 * j + 1);
        bus1.c_read_valid = 4'hF;
        while ((grants < 8 || busy1 || bus1.c_read_ready != 4'b0) && cyc < 200) begin
            tick();
            cyc++;
            bus1.m_read_ready[0] = bus1.m_read_valid[0];
            bus1.m_read_data[0] = 16'(cyc);
            if (bus1.m_read_valid[0]) begin
                want = 8'(16 * (grants % 4) + 1);
                checks++; if (bus1.m_read_address[0] !== want) begin errors++;
                    $display("FAIL fair_order_%0d got %h want %h", grants,
                             bus1.m_read_address[0], want); end
                grants++;
            end
            for (int j = 0; j < 4; j++) bus1.c_read_valid[j] = (grants < 8) && !bus1.c_read_ready[j];
        end
        checks++; if (cyc >= 200) begin errors++;
            $display("FAIL fair_timeout got %0d grants want 8", grants); end
        clear_inputs();
        for (int j = 0; j < 4; j++) begin
            checks++; if (gc1[j] !== 16'd2) begin errors++;
                $display("FAIL fair_grant_count%0d got %0d want 2", j, gc1[j]); end
        end
    endtask

    task automatic test_multi_channel();
        do_reset();
        bus2.c_read_valid[2] = 1'b1;
        bus2.c_read_address[2] = 8'h22;
        tick();
        checks++; if (bus2.m_read_valid !== 2'b01 || bus2.m_read_address[0] !== 8'h22) begin
            errors++; $display("FAIL multi_first got v=%b a=%h want v=01 a=22",
                               bus2.m_read_valid, bus2.m_read_address[0]); end
        bus2.m_read_ready = 2'b01;
        bus2.m_read_data[0] = 16'h2222;
        tick();
        bus2.m_read_ready = '0;
        bus2.c_read_valid = '0;
        tick();
        // rr_ptr now 3: channel 0 takes consumer 3, channel 1 wraps to consumer 1.
        bus2.c_read_address[1] = 8'h11;
        bus2.c_read_address[3] = 8'h33;
        bus2.c_read_valid = 4'b1010;
        tick();
        checks++; if (bus2.m_read_valid !== 2'b11) begin errors++;
            $display("FAIL multi_valid got %b want 11", bus2.m_read_valid); end
        checks++; if (bus2.m_read_address[0] !== 8'h33) begin errors++;
            $display("FAIL multi_ch0_addr got %h want 33", bus2.m_read_address[0]); end
        checks++; if (bus2.m_read_address[1] !== 8'h11) begin errors++;
            $display("FAIL multi_ch1_addr got %h want 11", bus2.m_read_address[1]); end
        checks++; if (gc2[1] !== 16'd1 || gc2[3] !== 16'd1) begin errors++;
            $display("FAIL multi_counts got %0d/%0d want 1/1", gc2[1], gc2[3]); end
        bus2.m_read_ready = 2'b11;
        bus2.m_read_data[0] = 16'h3333;
        bus2.m_read_data[1] = 16'h1111;
        tick();
        checks++; if (bus2.c_read_ready !== 4'b1010) begin errors++;
            $display("FAIL multi_c_read_ready got %b want 1010", bus2.c_read_ready); end
        checks++; if (bus2.c_read_data[3] !== 16'h3333 || bus2.c_read_data[1] !== 16'h1111) begin
            errors++; $display("FAIL multi_data got %h/%h want 3333/1111",
                               bus2.c_read_data[3], bus2.c_read_data[1]); end
        bus2.m_read_ready = '0;
        bus2.c_read_valid = '0;
        tick();
        // rr_ptr now 2: channel 0 takes consumer 2, channel 1 takes consumer 0.
        bus2.c_read_address[0] = 8'h01;
        bus2.c_read_address[2] = 8'h23;
        bus2.c_read_valid = 4'b0101;
        tick();
        checks++; if (bus2.m_read_address[0] !== 8'h23 || bus2.m_read_address[1] !== 8'h01) begin
            errors++; $display("FAIL multi_rr_ptr got %h/%h want 23/01",
                               bus2.m_read_address[0], bus2.m_read_address[1]); end
        checks++; if (gc2[0] !== 16'd1 || gc2[2] !== 16'd2) begin errors++;
            $display("FAIL multi_counts2 got %0d/%0d want 1/2", gc2[0], gc2[2]); end
        bus2.m_read_ready = 2'b11;
        tick();
        bus2.m_read_ready = '0;
        bus2.c_read_valid = '0;
        tick();
        checks++; if (busy2 !== 1'b0) begin errors++;
            $display("FAIL multi_busy_end got %0b want 0", busy2); end
    endtask

    task automatic test_rw_conflict();
        do_reset();
        bus1.c_read_valid[0] = 1'b1;
        bus1.c_read_address[0] = 8'h10;
        bus1.c_write_valid[0] = 1'b1;
        bus1.c_write_address[0] = 8'h20;
        bus1.c_write_data[0] = 16'h1234;
        tick();
        checks++; if (bus1.m_read_valid !== 1'b1 || bus1.m_read_address[0] !== 8'h10) begin
            errors++; $display("FAIL rw_read_first got v=%0b a=%h want v=1 a=10",
                               bus1.m_read_valid, bus1.m_read_address[0]); end
        checks++; if (bus1.m_write_valid !== 1'b0) begin errors++;
            $display("FAIL rw_no_write_yet got %0b want 0", bus1.m_write_valid); end
        bus1.m_read_ready[0] = 1'b1;
        bus1.m_read_data[0] = 16'h5A5A;
        tick();
        checks++; if (bus1.c_read_ready !== 4'b0001 || bus1.c_write_ready !== 4'b0000) begin
            errors++; $display("FAIL rw_read_ready got r=%b w=%b want r=0001 w=0000",
                               bus1.c_read_ready, bus1.c_write_ready); end
        bus1.m_read_ready = '0;
        bus1.c_read_valid = '0;
        tick();
        checks++; if (bus1.m_write_valid !== 1'b0) begin errors++;
            $display("FAIL rw_free_edge got %0b want 0", bus1.m_write_valid); end
        tick();
        checks++; if (bus1.m_write_valid !== 1'b1 || bus1.m_write_address[0] !== 8'h20) begin
            errors++; $display("FAIL rw_write_grant got v=%0b a=%h want v=1 a=20",
                               bus1.m_write_valid, bus1.m_write_address[0]); end
        checks++; if (bus1.m_write_data[0] !== 16'h1234) begin errors++;
            $display("FAIL rw_write_data got %h want 1234", bus1.m_write_data[0]); end
        bus1.c_write_data[0] = 16'hFFFF;
        bus1.c_write_address[0] = 8'h77;
        tick();
        checks++; if (bus1.m_write_data[0] !== 16'h1234 || bus1.m_write_address[0] !== 8'h20) begin
            errors++; $display("FAIL rw_latched got %h/%h want 1234/20",
                               bus1.m_write_data[0], bus1.m_write_address[0]); end
        bus1.m_write_ready[0] = 1'b1;
        tick();
        checks++; if (bus1.c_write_ready !== 4'b0001 || bus1.m_write_valid !== 1'b0) begin
            errors++; $display("FAIL rw_write_ack got w=%b mv=%0b want w=0001 mv=0",
                               bus1.c_write_ready, bus1.m_write_valid); end
        bus1.m_write_ready = '0;
        bus1.c_write_valid = '0;
        tick();
        checks++; if (bus1.c_write_ready !== 4'b0000 || gc1[0] !== 16'd2) begin errors++;
            $display("FAIL rw_end got w=%b cnt=%0d want w=0000 cnt=2", bus1.c_write_ready, gc1[0]);
        end
    endtask

    task automatic test_write_disabled();
        logic seen;
        seen = 1'b0;
        do_reset();
        bus3.c_write_valid[1] = 1'b1;
        bus3.c_write_address[1] = 8'h55;
        bus3.c_write_data[1] = 16'hABCD;
        repeat (4) begin
            tick();
            if (bus3.m_write_valid != 1'b0 || bus3.c_write_ready != 4'b0 || busy3) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL nowr_ignored got activity=1 want 0"); end
        checks++; if (bus3.m_write_address[0] !== 8'h00 || bus3.m_write_data[0] !== 16'h0) begin
            errors++; $display("FAIL nowr_tied got %h/%h want 00/0000",
                               bus3.m_write_address[0], bus3.m_write_data[0]); end
        bus3.c_read_valid[1] = 1'b1;
        bus3.c_read_address[1] = 8'h44;
        tick();
        checks++; if (bus3.m_read_valid !== 1'b1 || bus3.m_read_address[0] !== 8'h44) begin
            errors++; $display("FAIL nowr_read_grant got v=%0b a=%h want v=1 a=44",
                               bus3.m_read_valid, bus3.m_read_address[0]); end
        bus3.m_read_ready[0] = 1'b1;
        bus3.m_read_data[0] = 16'h0F0F;
        tick();
        checks++; if (bus3.c_read_ready !== 4'b0010 || bus3.c_read_data[1] !== 16'h0F0F) begin
            errors++; $display("FAIL nowr_read_done got r=%b d=%h want r=0010 d=0f0f",
                               bus3.c_read_ready, bus3.c_read_data[1]); end
        bus3.m_read_ready = '0;
        bus3.c_read_valid = '0;
        bus3.c_write_valid = '0;
        tick();
        checks++; if (gc3[1] !== 16'd1 || bus3.c_write_ready !== 4'b0000) begin errors++;
            $display("FAIL nowr_end got cnt=%0d w=%b want cnt=1 w=0000", gc3[1], bus3.c_write_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus1.c_read_valid[2] = 1'b1;
        bus1.c_read_address[2] = 8'h3C;
        tick();
        checks++; if (bus1.m_read_valid !== 1'b1) begin errors++;
            $display("FAIL midrst_setup got %0b want 1", bus1.m_read_valid); end
        reset = 1'b1;
        tick();
        checks++; if (bus1.m_read_valid !== 1'b0 || bus1.m_read_address[0] !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs got v=%0b a=%h want v=0 a=00",
                               bus1.m_read_valid, bus1.m_read_address[0]); end
        checks++; if (busy1 !== 1'b0 || gc1 !== 64'h0) begin errors++;
            $display("FAIL midrst_state got busy=%0b cnt=%h want 0/0", busy1, gc1); end
        reset = 1'b0;
        bus1.c_read_valid = '0;
        bus1.m_read_ready[0] = 1'b1;
        bus1.m_read_data[0] = 16'hDEAD;
        tick();
        checks++; if (bus1.c_read_ready !== 4'b0000 || bus1.c_read_data[2] !== 16'h0) begin
            errors++; $display("FAIL midrst_late_ready got r=%b d=%h want r=0000 d=0000",
                               bus1.c_read_ready, bus1.c_read_data[2]); end
        bus1.m_read_ready = '0;
        bus1.c_read_address[1] = 8'h11;
        bus1.c_read_address[3] = 8'h33;
        bus1.c_read_valid = 4'b1010;
        tick();
        checks++; if (bus1.m_read_address[0] !== 8'h11) begin errors++;
            $display("FAIL midrst_rr_ptr got %h want 11", bus1.m_read_address[0]); end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_multi_channel();
        test_rw_conflict();
        test_write_disabled();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
